// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB transfer, response and size encodings plus the memory subordinate FSM states.
package ahb_pkg;
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
    typedef enum logic [2:0] {
        HSIZE_BYTE   = 3'd0,
        HSIZE_HALF   = 3'd1,
        HSIZE_WORD   = 3'd2,
        HSIZE_DWORD  = 3'd3,
        HSIZE_4WORD  = 3'd4,
        HSIZE_8WORD  = 3'd5,
        HSIZE_16WORD = 3'd6,
        HSIZE_32WORD = 3'd7
    } hsize_t;
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} sub_state_t;
endpackage

// File: rtl/ahb_sub_bytemem.sv
// ahb_sub_bytemem: DEPTH x DATA_WIDTH storage with per-byte write enables and an asynchronous read.
module ahb_sub_bytemem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 256,
    localparam int LANES = DATA_WIDTH / 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic [LANES-1:0]      be,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        for (int b = 0; b < LANES; b++)
            if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    assign rdata = mem[addr];
endmodule

// File: rtl/ahb_mem_subordinate.sv
// ahb_mem_subordinate: AHB-Lite memory subordinate with WAIT_STATES wait states and a two-cycle ERROR response.
// Define AHB_SUB_RANGE_ERR_EN to turn out-of-range word indices into ERRORs instead of wrapping modulo DEPTH.
module ahb_mem_subordinate
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int OFF = $clog2(LANES);
    localparam int AW = $clog2(DEPTH);

    sub_state_t state, state_d;
    logic [3:0] cnt;
    logic [AW-1:0] idx;
    logic [LANES-1:0] be_q, be_d, we;
    logic wr_q;
    logic [DATA_WIDTH-1:0] rdata_q, mem_rd;
    logic [ADDR_WIDTH-1:0] word, align_mask;
    logic accept, open_phase, illegal, in_range;
    logic unused;

    assign unused = ^HBURST;
    assign word = HADDR >> OFF;
    assign align_mask = (ADDR_WIDTH'(1) << HSIZE) - ADDR_WIDTH'(1);
`ifdef AHB_SUB_RANGE_ERR_EN
    assign in_range = word < ADDR_WIDTH'(DEPTH);
`else
    assign in_range = 1'b1;
`endif
    assign illegal = HSIZE > 3'(OFF) || (HADDR & align_mask) != '0 || !in_range;
    assign open_phase = state == S_IDLE || state == S_DATA || state == S_ERR2;
    assign accept = open_phase && HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
    // 2**HSIZE enabled lanes starting at the byte offset inside the word
    assign be_d = ((LANES'(1) << (LANES'(1) << HSIZE)) - LANES'(1)) << HADDR[OFF-1:0];
    assign we = state == S_DATA && wr_q ? be_q : '0;

    always_ff @(posedge HCLK or posedge HRESET)
        if (HRESET) begin
            state <= S_IDLE;
            cnt <= '0;
        end else begin
            state <= state_d;
            cnt <= state == S_WAIT ? cnt + 4'd1 : 4'd0;
        end

    always_comb
        state_d = open_phase ? (accept ? (illegal ? S_ERR1 : WAIT_STATES > 0 ? S_WAIT : S_DATA) : S_IDLE)
                : state == S_ERR1 ? S_ERR2
                : cnt == 4'(WAIT_STATES - 1) ? S_DATA : S_WAIT;

    always_comb begin
        HREADYOUT = !(state == S_WAIT || state == S_ERR1);
        HRESP = state == S_ERR1 || state == S_ERR2 ? HRESP_ERROR : HRESP_OKAY;
        HRDATA = state == S_DATA && !wr_q ? mem_rd : rdata_q;
    end

    always_ff @(posedge HCLK or posedge HRESET)
        if (HRESET) begin
            idx <= '0;
            be_q <= '0;
            wr_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                idx <= AW'(word % ADDR_WIDTH'(DEPTH));
                be_q <= be_d;
                wr_q <= HWRITE;
            end
            if (state == S_DATA && !wr_q) rdata_q <= mem_rd;
        end

    ahb_sub_bytemem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk(HCLK),
        .be(we),
        .addr(idx),
        .wdata(HWDATA),
        .rdata(mem_rd)
    );
endmodule

// File: tb/tb_ahb_mem_subordinate.sv
// tb_ahb_mem_subordinate: directed AHB transfers into two subordinates (0 and 3 wait states) checked against a transfer-level model.
module tb_ahb_mem_subordinate;
    import ahb_pkg::*;
    localparam int WS_A = 0;
    localparam int WS_B = 3;
`ifdef AHB_SUB_RANGE_ERR_EN
    localparam logic RANGE_ERR = 1'b1;
`else
    localparam logic RANGE_ERR = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b0;
    logic sel0 = 1'b0, sel1 = 1'b0, hwrite = 1'b0;
    logic [31:0] haddr = '0, hwdata = '0;
    logic [1:0] htrans = HTRANS_IDLE;
    logic [2:0] hsize = '0;
    logic [31:0] rdata0, rdata1;
    logic rdy0, rdy1, resp0, resp1;
    int vectors = 0, miscompares = 0;

    ahb_mem_subordinate #(.WAIT_STATES(WS_A)) u_a (
        .HCLK(clk), .HRESET(rst), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(3'b000), .HWDATA(hwdata), .HREADY(rdy0),
        .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0));
    ahb_mem_subordinate #(.WAIT_STATES(WS_B)) u_b (
        .HCLK(clk), .HRESET(rst), .HSEL(sel1), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(3'b000), .HWDATA(hwdata), .HREADY(rdy1),
        .HRDATA(rdata1), .HREADYOUT(rdy1), .HRESP(resp1));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: a transfer owns pn cycles of data phase; only the last one is ready.
    int pn [2], pword [2], poff [2], plen [2];
    bit pe [2], pw [2];
    logic [31:0] mm [2][256];
    logic [31:0] last [2];

    function automatic int ws_of(int i);
        return i == 0 ? WS_A : WS_B;
    endfunction

    function automatic bit illegal_f(logic [31:0] a, logic [2:0] s);
        illegal_f = s > 3'd2 || (a % (32'd1 << s)) != 0;
        if (RANGE_ERR && a / 4 >= 256) illegal_f = 1'b1;
    endfunction

    always @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                pn[i] <= 0;
                last[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (pn[i] == 1 && !pe[i]) begin
                    if (pw[i]) begin
                        for (int b = 0; b < 4; b++)
                            if (b >= poff[i] && b < poff[i] + plen[i]) mm[i][pword[i]][8*b +: 8] <= hwdata[8*b +: 8];
                    end else last[i] <= mm[i][pword[i]];
                end
                if ((i == 0 ? sel0 : sel1) && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ) && pn[i] <= 1) begin
                    pe[i] <= illegal_f(haddr, hsize);
                    pw[i] <= hwrite;
                    pword[i] <= int'((haddr / 4) % 256);
                    poff[i] <= int'(haddr % 4);
                    plen[i] <= 1 << hsize;
                    pn[i] <= illegal_f(haddr, hsize) ? 2 : ws_of(i) + 1;
                end else if (pn[i] > 0) pn[i] <= pn[i] - 1;
            end
        end

    always @(negedge clk)
        for (int i = 0; i < 2; i++) begin
            automatic logic er = pn[i] <= 1;
            automatic logic ep = pn[i] > 0 && pe[i];
            automatic logic [31:0] ed = (pn[i] == 1 && !pe[i] && !pw[i]) ? mm[i][pword[i]] : last[i];
            check($sformatf("bus_u%0d {ready,resp,rdata}", i),
                  i == 0 ? {rdy0, resp0, rdata0} : {rdy1, resp1, rdata1}, {er, ep, ed});
        end

    function automatic logic rdy_of(int i);
        return i == 0 ? rdy0 : rdy1;
    endfunction

    // Presents one address phase and returns just after it is accepted, data phase driven.
    task automatic xfer(input int i, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [1:0] tr = HTRANS_NONSEQ);
        int n = 0;
        logic r;
        sel0 = i == 0;
        sel1 = i == 1;
        haddr = a;
        hwrite = wr;
        hsize = sz;
        htrans = tr;
        forever begin
            r = rdy_of(i);
            @(posedge clk);
            n++;
            if (r || n >= 50) break;
            #1;
        end
        check($sformatf("accept_u%0d_%h", i, a), {63'd0, r}, 64'd1);
        #1;
        hwdata = wd;
        sel0 = 1'b0;
        sel1 = 1'b0;
        htrans = HTRANS_IDLE;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic exp_r [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_u0", {rdy0, resp0, rdata0}, {1'b1, 1'b0, 32'h0});
        check("reset_u1", {rdy1, resp1, rdata1}, {1'b1, 1'b0, 32'h0});
        rst = 1'b0;
        xfer(0, 1, 32'h10, HSIZE_WORD, 32'hDEADBEEF);
        @(negedge clk);
        check("wr10_ready", {rdy0, resp0}, 2'b10);
        xfer(0, 0, 32'h10, HSIZE_WORD, 32'h0);
        @(negedge clk);
        check("rd10", rdata0, 32'hDEADBEEF);
        xfer(0, 1, 32'h20, HSIZE_WORD, 32'h11223344);
        xfer(0, 1, 32'h21, HSIZE_BYTE, 32'h0000AA00);
        xfer(0, 0, 32'h20, HSIZE_WORD, 32'h0);
        @(negedge clk);
        check("rd20_byte", rdata0, 32'h1122AA44);
        xfer(0, 1, 32'h22, HSIZE_HALF, 32'hBEEF0000);
        xfer(0, 0, 32'h20, HSIZE_WORD, 32'h0);
        @(negedge clk);
        check("rd20_half", rdata0, 32'hBEEFAA44);
        xfer(0, 1, 32'h00, HSIZE_WORD, 32'h01020304);
        xfer(0, 1, 32'h02, HSIZE_WORD, 32'hFFFFFFFF);
        @(negedge clk);
        check("misalign_c1", {rdy0, resp0}, 2'b01);
        @(negedge clk);
        check("misalign_c2", {rdy0, resp0}, 2'b11);
        xfer(0, 0, 32'h00, HSIZE_WORD, 32'h0);
        @(negedge clk);
        check("rd00_unchanged", rdata0, 32'h01020304);
        xfer(0, 0, 32'h08, HSIZE_DWORD, 32'h0);
        @(negedge clk);
        check("dword_err", {rdy0, resp0}, 2'b01);
        xfer(0, 1, 32'h400, HSIZE_WORD, 32'hCAFEF00D);
        @(negedge clk);
        check("range_resp", {63'd0, resp0}, {63'd0, RANGE_ERR});
        xfer(0, 0, 32'h00, HSIZE_WORD, 32'h0);
        @(negedge clk);
        check("rd00_range", rdata0, RANGE_ERR ? 32'h01020304 : 32'hCAFEF00D);
        xfer(0, 1, 32'h40, HSIZE_WORD, 32'hA5A50001, HTRANS_NONSEQ);
        xfer(0, 1, 32'h44, HSIZE_WORD, 32'hA5A50002, HTRANS_SEQ);
        xfer(0, 0, 32'h40, HSIZE_WORD, 32'h0, HTRANS_NONSEQ);
        @(negedge clk);
        check("rd40_seq", rdata0, 32'hA5A50001);
        xfer(0, 0, 32'h44, HSIZE_WORD, 32'h0, HTRANS_SEQ);
        @(negedge clk);
        check("rd44_seq", rdata0, 32'hA5A50002);
        sel0 = 1'b1;
        haddr = 32'h10;
        hwrite = 1'b1;
        htrans = HTRANS_BUSY;
        @(posedge clk);
        #1;
        htrans = HTRANS_IDLE;
        @(negedge clk);
        check("busy_idle_okay", {rdy0, resp0, rdata0}, {1'b1, 1'b0, 32'hA5A50002});
        @(posedge clk);
        #1;
        sel0 = 1'b0;
        xfer(1, 1, 32'h04, HSIZE_WORD, 32'h0BADCAFE);
        xfer(1, 0, 32'h04, HSIZE_WORD, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("ws3_cycle%0d", k), {rdy1, resp1}, {exp_r[k], 1'b0});
        end
        check("ws3_rd04", rdata1, 32'h0BADCAFE);
        xfer(1, 1, 32'h30, HSIZE_WORD, 32'h55AA55AA);
        xfer(1, 1, 32'h30, HSIZE_WORD, 32'h12345678);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midreset_u1", {rdy1, resp1, rdata1}, {1'b1, 1'b0, 32'h0});
        check("midreset_u0", rdata0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        xfer(1, 0, 32'h30, HSIZE_WORD, 32'h0);
        repeat (4) @(negedge clk);
        check("rd30_after_reset", {rdy1, rdata1}, {1'b1, 32'h55AA55AA});
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
